// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator
//   Consumes a stream of signed operand pairs (a_i, b_i), accumulates
//   VEC_LEN products into one signed dot-product result and flags any
//   signed overflow of the ACC_W-bit accumulator (sticky per vector).
//
//   Optional build macro: DOT_ACC_SATURATE_EN
//     defined   -> on a step overflow the accumulator clamps to the signed
//                  max/min of ACC_W bits and later steps continue from it.
//     undefined -> the accumulator wraps modulo 2^ACC_W.
//     out_ovf is reported identically in both builds.
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     in_valid   operand pair valid
//     in_ready   block can accept a pair (state-derived, 0 while a result
//                is pending)
//     in_a,in_b  signed operands, DATA_W bits
//     out_valid  result valid
//     out_ready  consumer accepts the result
//     out_data   signed dot product, ACC_W bits (held after out_valid drops)
//     out_ovf    accumulation overflowed the ACC_W signed range
module dot_product_accumulator #(
    parameter int DATA_W  = 8,
    parameter int VEC_LEN = 4,
    parameter int ACC_W   = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_a,
    input  logic signed [DATA_W-1:0] in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [ACC_W-1:0]  out_data,
    output logic                     out_ovf
);

    generate
        if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
            $error("dot_product_accumulator: ACC_W must be >= 2*DATA_W");
        end
        if (VEC_LEN < 1) begin : g_bad_vec_len
            $error("dot_product_accumulator: VEC_LEN must be >= 1");
        end
    endgenerate

    localparam int                CNT_W   = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(VEC_LEN);
    localparam logic [ACC_W-1:0]  POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  NEG_MAX = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;

    logic signed [2*DATA_W-1:0] prod;
    logic        [ACC_W:0]      p_ext;
    logic        [ACC_W:0]      sum;
    logic                       step_ovf;
    logic        [ACC_W-1:0]    step_acc;
    logic                       in_fire;

    // Product and one extra guard bit so overflow shows up as a mismatch
    // between the two top bits of the sum.
    always_comb begin
        prod     = in_a * in_b;
        p_ext    = {{(ACC_W + 1 - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
        sum      = {acc_q[ACC_W-1], acc_q} + p_ext;
        step_ovf = sum[ACC_W] != sum[ACC_W-1];
`ifdef DOT_ACC_SATURATE_EN
        // sum[ACC_W] is the true sign of the unbounded result.
        step_acc = step_ovf ? (sum[ACC_W] ? NEG_MAX : POS_MAX) : sum[ACC_W-1:0];
`else
        step_acc = sum[ACC_W-1:0];
`endif
    end

    // No path from out_ready: ready depends on state alone.
    assign in_ready = (state_q != DONE);
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    // First product always fits since ACC_W >= 2*DATA_W.
                    acc_d   = p_ext[ACC_W-1:0];
                    ovf_d   = 1'b0;
                    count_d = CNT_W'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_fire) begin
                    acc_d   = step_acc;
                    ovf_d   = ovf_q | step_ovf;
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    count_d     = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Last element accepted: publish the registered result next cycle.
        if (in_fire && count_d == LAST) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = acc_d;
            out_ovf_d   = ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench for dot_product_accumulator: default instance driven
// from a vector table plus hand sequences for backpressure and reset, an
// ACC_W=16 instance for overflow, and a VEC_LEN=1 instance.
module tb_dot_product_accumulator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default instance (VEC_LEN=4, ACC_W=20)
    logic              in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic signed [7:0] in_a, in_b;
    logic       [19:0] out_data;

    // ACC_W=16 instance
    logic              w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_ovf;
    logic signed [7:0] w_in_a, w_in_b;
    logic       [15:0] w_out_data;

    // VEC_LEN=1 instance
    logic              s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_ovf;
    logic signed [7:0] s_in_a, s_in_b;
    logic       [19:0] s_out_data;

    dot_product_accumulator u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    dot_product_accumulator #(.ACC_W(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_a(w_in_a), .in_b(w_in_b), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_data(w_out_data), .out_ovf(w_out_ovf)
    );

    dot_product_accumulator #(.VEC_LEN(1)) u_v1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_ovf(s_out_ovf)
    );

    typedef struct {
        logic signed [7:0] a [4];
        logic signed [7:0] b [4];
        int                gap;
        int                exp_data;
        logic              exp_ovf;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int a0, a1, a2, a3, b0, b1, b2, b3,
                                input int gap, input int exp_data);
        vec_t v;
        v.a[0] = 8'(a0); v.a[1] = 8'(a1); v.a[2] = 8'(a2); v.a[3] = 8'(a3);
        v.b[0] = 8'(b0); v.b[1] = 8'(b1); v.b[2] = 8'(b2); v.b[3] = 8'(b3);
        v.gap      = gap;
        v.exp_data = exp_data;
        v.exp_ovf  = 1'b0;
        return v;
    endfunction

    // Feed the four elements starting at a negedge; returns at the negedge
    // after the final accept with in_valid low.
    task automatic feed(input vec_t v);
        for (int k = 0; k < 4; k++) begin
            if (k > 0 && v.gap > 0) begin
                in_valid = 1'b0;
                repeat (v.gap) @(negedge clk);
            end
            in_valid = 1'b1;
            in_a     = v.a[k];
            in_b     = v.b[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Full vector with out_ready held high: result visible one cycle after
    // the last accept, then drains to IDLE on the next edge.
    task automatic run_vec(input string name, input vec_t v);
        out_ready = 1'b1;
        feed(v);
        chk({name, " out_valid"}, int'(out_valid), 1);
        chk({name, " out_data"},  int'($signed(out_data)), v.exp_data);
        chk({name, " out_ovf"},   int'(out_ovf), int'(v.exp_ovf));
        chk({name, " in_ready_done"}, int'(in_ready), 0);
        @(negedge clk);
        chk({name, " out_valid_drop"}, int'(out_valid), 0);
        chk({name, " in_ready_back"},  int'(in_ready), 1);
        chk({name, " data_retained"},  int'($signed(out_data)), v.exp_data);
    endtask

    vec_t vecs [7];
    vec_t v;
    int   held;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = mk(1, 2, 3, 4, 5, 6, 7, 8, 0, 70);
        vecs[1] = mk(-128, 127, -1, 0, -128, -128, 5, 99, 0, 123);
        vecs[2] = mk(1, 2, 3, 4, 5, 6, 7, 8, 1, 70);
        vecs[3] = mk(1, 2, 3, 4, 5, 6, 7, 8, 2, 70);
        vecs[4] = mk(1, 2, 3, 4, 5, 6, 7, 8, 3, 70);
        vecs[5] = mk(-128, -128, -128, -128, 127, 127, 127, 127, 0, -65024);
        vecs[6] = mk(127, 127, 127, 127, 127, 127, 127, 127, 1, 64516);

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_data",  int'(out_data), 0);
        chk("reset out_ovf",   int'(out_ovf), 0);
        chk("reset in_ready",  int'(in_ready), 1);

        for (int i = 0; i < 7; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: result must hold and extra inputs must be refused.
        out_ready = 1'b0;
        feed(vecs[0]);
        chk("bp out_valid", int'(out_valid), 1);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_a = 8'sd100; in_b = 8'sd100;
            @(negedge clk);
            chk("bp hold valid",   int'(out_valid), 1);
            chk("bp hold data",    int'($signed(out_data)), 70);
            chk("bp hold ovf",     int'(out_ovf), 0);
            chk("bp in_ready low", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp release valid", int'(out_valid), 0);
        chk("bp release ready", int'(in_ready), 1);
        run_vec("bp next", mk(1, 1, 1, 1, 2, 2, 2, 2, 0, 8));

        // Reset mid-vector discards the partial sum.
        v = vecs[0];
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_a = 8'sd50; in_b = 8'sd50;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst in_ready",  int'(in_ready), 1);
        held = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (out_valid) held++;
        end
        chk("midrst no output", held, 0);
        run_vec("after rst", v);

        // ACC_W=16 overflow: 4 * 16384 = 65536.
        for (int k = 0; k < 4; k++) begin
            w_in_valid = 1'b1; w_in_a = -8'sd128; w_in_b = -8'sd128;
            @(negedge clk);
        end
        w_in_valid = 1'b0;
        chk("w16 out_valid", int'(w_out_valid), 1);
`ifdef DOT_ACC_SATURATE_EN
        chk("w16 out_data", int'($signed(w_out_data)), 32767);
`else
        chk("w16 out_data", int'($signed(w_out_data)), 0);
`endif
        chk("w16 out_ovf", int'(w_out_ovf), 1);
        @(negedge clk);
        chk("w16 drain", int'(w_out_valid), 0);

        // VEC_LEN=1: single element completes immediately.
        s_in_valid = 1'b1; s_in_a = -8'sd3; s_in_b = 8'sd7;
        @(negedge clk);
        s_in_valid = 1'b0;
        chk("v1 out_valid", int'(s_out_valid), 1);
        chk("v1 out_data",  int'($signed(s_out_data)), -21);
        chk("v1 out_ovf",   int'(s_out_ovf), 0);
        chk("v1 in_ready",  int'(s_in_ready), 0);
        @(negedge clk);
        chk("v1 drain", int'(s_out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_product_accumulator.md
Name: dot_product_accumulator

Overview:
- Sequential stage downstream of the 8-bit signed adder in the MatrixMultiplier datapath.
- Consumes a stream of signed operand pairs (a_i, b_i) and forms products.
- Accumulates VEC_LEN products into one dot-product result (one output matrix element), with overflow detection.
- Valid/ready handshakes on both input and output, so it sits between the operand fetch logic and the result writeback.

Parameters:
- DATA_W, 8, width of each signed operand (two's complement).
- VEC_LEN, 4, products per dot product; legal range is 1 or more.
- ACC_W, 20, signed accumulator and result width; must be at least 2*DATA_W (elaboration error otherwise).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- in_a  in  DATA_W  signed operand a_i.
- in_b  in  DATA_W  signed operand b_i.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  signed dot-product result.
- out_ovf  out  1  the vector's accumulation overflowed ACC_W signed range.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset:
  - state goes to IDLE; count = 0; acc = 0; ovf = 0.
  - out_valid = 0, out_data = 0, out_ovf = 0, in_ready = 1 (from the cycle after reset).
- Reset mid-vector or while in DONE discards partial or pending results. No output is produced for the discarded vector.
- Handshake transfer: a transfer occurs when valid && ready is high at a rising edge.
- in_ready = 1 in IDLE and ACCUM, 0 in DONE. It is registered/state-derived and has no combinational path from out_ready.
- Product: p = signed(in_a) * signed(in_b), 2*DATA_W bits, sign-extended to ACC_W+1 bits.
- Sum: sum = {acc[ACC_W-1], acc} + p_ext, computed in ACC_W+1 bits. Overflow on a step when sum[ACC_W] != sum[ACC_W-1].
- State IDLE:
  - On input transfer: acc = p_ext truncated to ACC_W (the first product cannot overflow); ovf = 0; count = 1.
  - Next state is ACCUM, or DONE if VEC_LEN == 1.
- State ACCUM:
  - On input transfer: acc = sum[ACC_W-1:0] (or the saturated value; see Optional Feature); ovf |= step overflow; count++.
  - When the transfer makes count == VEC_LEN, go to DONE.
  - With no transfer (bubble), hold all registers.
- Entering DONE:
  - out_valid = 1, out_data = final acc, out_ovf = sticky ovf.
  - These are registered: they are visible the cycle after the final input transfer. Latency from last input accept to out_valid is 1 cycle.
- State DONE:
  - Hold out_data/out_ovf stable while out_valid && !out_ready.
  - On output transfer: out_valid = 0, count = 0, go to IDLE. in_ready returns to 1 the following cycle; no same-cycle input accept in DONE.
- Boundary conditions:
  - A counter of width $clog2(VEC_LEN+1) never wraps.
  - in_valid asserted while in_ready = 0 is ignored, and the operands are not consumed.
  - out_data/out_ovf retain their last value after out_valid drops.

Optional Feature:
- Macro: DOT_ACC_SATURATE_EN.
- Defined: on a step overflow, acc clamps to +(2^(ACC_W-1)-1) if sum is positive-overflowed (sum[ACC_W] = 0), or to -(2^(ACC_W-1)) if negative-overflowed. Later steps continue from the clamped value. out_ovf is still set.
- Not defined: acc wraps modulo 2^ACC_W (keeps sum[ACC_W-1:0]); out_ovf is set identically.

Test Plan:
- Defaults (VEC_LEN=4, ACC_W=20), back-to-back a={1,2,3,4}, b={5,6,7,8}, out_ready=1 -> out_valid 1 cycle after the 4th accept, out_data=70, out_ovf=0, in_ready returns to 1 afterwards.
- Signed operands: a={-128,127,-1,0}, b={-128,-128,5,99} -> out_data=16384-16256-5=123, out_ovf=0.
- ACC_W=16, a=b={-128,-128,-128,-128}:
  - Macro undefined -> out_data=0 (65536 wraps), out_ovf=1.
  - Macro defined -> out_data=32767, out_ovf=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data/out_ovf stable and in_ready=0 throughout. Extra in_valid pulses during this time are not accepted. out_ready=1 -> IDLE; the next vector {1,1,1,1}·{2,2,2,2} -> 8.
- Bubbles and reset: after in_valid gaps of 0-3 cycles between elements the result is unchanged (70). Asserting rst after 2 accepts -> out_valid stays 0, and the next full vector {1,2,3,4}·{5,6,7,8} -> 70 (no carry-over from the discarded vector).
- VEC_LEN=1: a=-3, b=7 -> out_data=-21 one cycle after accept, out_ovf=0.
